// File: rtl/boot_loader_if.sv
// Boot loader bundle: serial input, instruction-memory write port and core/status outputs.
// The loader drives the memory side through the master modport.
`timescale 1ns/1ps
interface boot_loader_if;
    logic        uart_rx;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        core_reset;
    logic        busy;
    logic        done;
    logic        error;

    modport master (
        input  uart_rx,
        output imem_we, imem_addr, imem_wdata, core_reset, busy, done, error
    );

    modport slave (
        output uart_rx,
        input  imem_we, imem_addr, imem_wdata, core_reset, busy, done, error
    );
endinterface

// File: rtl/boot_loader.sv
// UART program loader: receives a length-prefixed image, writes it word-by-word into
// instruction memory and holds the core in reset until the image is complete.
`timescale 1ns/1ps
module boot_loader #(
    parameter int unsigned CLKS_PER_BIT = 104,
    parameter int unsigned MAX_WORDS    = 2048
) (
    input  logic          clk_i,
    input  logic          reset_ni,
    boot_loader_if.master bus
);
    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
    typedef enum logic [2:0] {StLenLo, StLenHi, StWord, StWrite, StDone, StError} ld_state_e;

    logic            rx_meta_q, rx_sync_q;
    rx_state_e       rx_state_q, rx_state_d;
    logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]      rx_bit_q, rx_bit_d;
    logic [7:0]      rx_shift_q, rx_shift_d;
    logic            byte_valid_q, byte_valid_d;
    logic            frame_err_q, frame_err_d;

    ld_state_e   state_q, state_d;
    logic [15:0] count_q, count_d;
    logic [15:0] widx_q, widx_d;
    logic [1:0]  bidx_q, bidx_d;
    logic [31:0] asm_q, asm_d;
    logic [15:0] new_count;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            rx_state_q   <= RxIdle;
            rx_cnt_q     <= '0;
            rx_bit_q     <= '0;
            rx_shift_q   <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            state_q      <= StLenLo;
            count_q      <= '0;
            widx_q       <= '0;
            bidx_q       <= '0;
            asm_q        <= '0;
        end else begin
            rx_meta_q    <= bus.uart_rx;
            rx_sync_q    <= rx_meta_q;
            rx_state_q   <= rx_state_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_bit_q     <= rx_bit_d;
            rx_shift_q   <= rx_shift_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
            state_q      <= state_d;
            count_q      <= count_d;
            widx_q       <= widx_d;
            bidx_q       <= bidx_d;
            asm_q        <= asm_d;
        end
    end

    // Receiver: mid-bit sampling of the synchronised line, LSB first.
    always_comb begin
        rx_state_d   = rx_state_q;
        rx_cnt_d     = rx_cnt_q;
        rx_bit_d     = rx_bit_q;
        rx_shift_d   = rx_shift_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        unique case (rx_state_q)
            RxIdle: begin
                if (!rx_sync_q) begin
                    rx_state_d = RxStart;
                    rx_cnt_d   = '0;
                end
            end
            RxStart: begin
                if (rx_cnt_q == HalfLast) begin
                    rx_cnt_d = '0;
                    rx_bit_d = '0;
                    rx_state_d = rx_sync_q ? RxIdle : RxData;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RxData: begin
                if (rx_cnt_q == BitLast) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) rx_state_d = RxStop;
                    else                  rx_bit_d   = rx_bit_q + 1'b1;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RxStop: begin
                if (rx_cnt_q == BitLast) begin
                    rx_cnt_d     = '0;
                    byte_valid_d = rx_sync_q;
                    frame_err_d  = !rx_sync_q;
                    rx_state_d   = RxIdle;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            default: rx_state_d = RxIdle;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        widx_d    = widx_q;
        bidx_d    = bidx_q;
        asm_d     = asm_q;
        new_count = {rx_shift_q, count_q[7:0]};
        unique case (state_q)
            StLenLo: begin
                if (byte_valid_q) begin
                    count_d[7:0] = rx_shift_q;
                    state_d      = StLenHi;
                end
            end
            StLenHi: begin
                if (byte_valid_q) begin
                    count_d = new_count;
                    widx_d  = '0;
                    bidx_d  = '0;
                    if (new_count == 16'd0)                        state_d = StDone;
                    else if ({16'd0, new_count} > 32'(MAX_WORDS)) state_d = StError;
                    else                                           state_d = StWord;
                end
            end
            StWord: begin
                if (byte_valid_q) begin
                    unique case (bidx_q)
                        2'd0: asm_d[7:0]   = rx_shift_q;
                        2'd1: asm_d[15:8]  = rx_shift_q;
                        2'd2: asm_d[23:16] = rx_shift_q;
                        2'd3: asm_d[31:24] = rx_shift_q;
                        default: asm_d = asm_q;
                    endcase
                    bidx_d = bidx_q + 2'd1;
                    if (bidx_q == 2'd3) state_d = StWrite;
                end
            end
            StWrite: begin
                if (widx_q + 16'd1 == count_q) begin
                    state_d = StDone;
                end else begin
                    widx_d  = widx_q + 16'd1;
                    state_d = StWord;
                end
            end
            StDone:  state_d = StDone;
            StError: state_d = StError;
            default: state_d = StError;
        endcase
        // A bad stop bit aborts any unfinished load; a half-built word is dropped.
        if (frame_err_q && state_q != StDone && state_q != StError) state_d = StError;
    end

    assign bus.imem_we    = (state_q == StWrite);
    assign bus.imem_addr  = {14'd0, widx_q, 2'b00};
    assign bus.imem_wdata = asm_q;
    assign bus.core_reset = (state_q != StDone);
    assign bus.busy       = (state_q == StLenHi) || (state_q == StWord) || (state_q == StWrite);
    assign bus.done       = (state_q == StDone);
    assign bus.error      = (state_q == StError);
endmodule

// File: tb/tb_boot_loader.sv
// Bench for boot_loader: directed and random UART images checked against a stream-level model.
`timescale 1ns/1ps
module tb_boot_loader;
    localparam int unsigned Cpb  = 4;
    localparam int unsigned MaxW = 2048;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    boot_loader_if bus();

    boot_loader #(.CLKS_PER_BIT(Cpb), .MAX_WORDS(MaxW)) dut (
        .clk_i    (clk),
        .reset_ni (reset_n),
        .bus      (bus)
    );

    int checks   = 0;
    int failures = 0;

    int   cyc         = 0;
    int   done_cyc    = -1;
    int   last_we_cyc = -1;
    logic done_prev   = 1'b0;
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];

    logic [7:0]  tx_b[$];
    bit          tx_ok[$];
    logic [31:0] exp_a[$];
    logic [31:0] exp_d[$];
    logic        exp_done, exp_err, exp_busy;

    // Write-port monitor: one queue entry per cycle with the strobe high.
    always @(negedge clk) begin
        cyc++;
        if (bus.imem_we === 1'b1) begin
            wr_addr_q.push_back(bus.imem_addr);
            wr_data_q.push_back(bus.imem_wdata);
            last_we_cyc = cyc;
        end
        if (bus.done === 1'b1 && !done_prev) done_cyc = cyc;
        done_prev = (bus.done === 1'b1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic send_bit(input logic v);
        bus.uart_rx = v;
        repeat (Cpb) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        @(posedge clk);
        #1;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop_ok);
        send_bit(1'b1);
        send_bit(1'b1);
    endtask

    // Image semantics: the usable stream ends at the first bad stop bit.
    function automatic void build_model();
        int fe;
        int n;
        int base;
        fe = tx_b.size();
        for (int i = 0; i < tx_b.size(); i++) begin
            if (!tx_ok[i]) begin
                fe = i;
                break;
            end
        end
        exp_a.delete();
        exp_d.delete();
        exp_done = 1'b0;
        exp_err  = 1'b0;
        exp_busy = 1'b0;
        if (fe < 2) begin
            exp_err  = (fe < tx_b.size());
            exp_busy = !exp_err && (fe == 1);
            return;
        end
        n = int'(tx_b[0]) + 256 * int'(tx_b[1]);
        if (n == 0) begin
            exp_done = 1'b1;
            return;
        end
        if (n > int'(MaxW)) begin
            exp_err = 1'b1;
            return;
        end
        for (int k = 0; k < n; k++) begin
            base = 2 + 4 * k;
            if (base + 4 > fe) break;
            exp_a.push_back(32'(4 * k));
            exp_d.push_back({tx_b[base+3], tx_b[base+2], tx_b[base+1], tx_b[base]});
        end
        if (exp_a.size() == n)      exp_done = 1'b1;
        else if (fe < tx_b.size()) exp_err  = 1'b1;
        else                        exp_busy = 1'b1;
    endfunction

    task automatic run_and_check(input string tag);
        int nchk;
        build_model();
        wr_addr_q.delete();
        wr_data_q.delete();
        done_cyc    = -1;
        last_we_cyc = -1;
        for (int i = 0; i < tx_b.size(); i++) send_byte(tx_b[i], tx_ok[i]);
        repeat (20) @(posedge clk);
        #1;
        check({tag, " nwrites"}, 32'(wr_addr_q.size()), 32'(exp_a.size()));
        nchk = (wr_addr_q.size() < exp_a.size()) ? wr_addr_q.size() : exp_a.size();
        for (int i = 0; i < nchk; i++) begin
            check($sformatf("%s addr%0d", tag, i), wr_addr_q[i], exp_a[i]);
            check($sformatf("%s data%0d", tag, i), wr_data_q[i], exp_d[i]);
        end
        check({tag, " done"}, 32'(bus.done), 32'(exp_done));
        check({tag, " error"}, 32'(bus.error), 32'(exp_err));
        check({tag, " core_reset"}, 32'(bus.core_reset), 32'(!exp_done));
        check({tag, " busy"}, 32'(bus.busy), 32'(exp_busy));
        if (exp_done && exp_a.size() > 0)
            check({tag, " done_lat"}, 32'(done_cyc), 32'(last_we_cyc + 1));
    endtask

    task automatic do_reset();
        reset_n     = 1'b0;
        bus.uart_rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic set_stream(input logic [7:0] b[$]);
        tx_b.delete();
        tx_ok.delete();
        foreach (b[i]) begin
            tx_b.push_back(b[i]);
            tx_ok.push_back(1'b1);
        end
    endtask

    initial begin
        int n;
        reset_n     = 1'b0;
        bus.uart_rx = 1'b1;

        // Reset holds everything quiet even with the line toggling.
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            bus.uart_rx = i[0];
        end
        @(negedge clk);
        check("rst imem_we", 32'(bus.imem_we), 32'd0);
        check("rst imem_addr", bus.imem_addr, 32'd0);
        check("rst imem_wdata", bus.imem_wdata, 32'd0);
        check("rst core_reset", 32'(bus.core_reset), 32'd1);
        check("rst busy", 32'(bus.busy), 32'd0);
        check("rst done", 32'(bus.done), 32'd0);
        check("rst error", 32'(bus.error), 32'd0);
        do_reset();

        set_stream('{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00});
        run_and_check("two_word");
        check("two_word d1", wr_data_q.size() > 1 ? wr_data_q[1] : 32'hx, 32'h0010_0113);

        do_reset();
        set_stream('{8'h00, 8'h00});
        run_and_check("empty");

        do_reset();
        set_stream('{8'h01, 8'h08, 8'h11, 8'h22, 8'h33, 8'h44});
        run_and_check("oversize");

        // A one-cycle low glitch must not turn into a length byte.
        do_reset();
        @(posedge clk);
        #1;
        bus.uart_rx = 1'b0;
        @(posedge clk);
        #1;
        bus.uart_rx = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        check("false_start busy", 32'(bus.busy), 32'd0);
        set_stream('{8'h00, 8'h00});
        run_and_check("false_start");

        do_reset();
        set_stream('{8'h01, 8'h00, 8'h5A});
        tx_ok[2] = 1'b0;
        run_and_check("frame_err");

        do_reset();
        set_stream('{8'h01, 8'h00, 8'hAA, 8'hBB});
        run_and_check("partial");
        #3;
        reset_n = 1'b0;
        #2;
        check("async_rst busy", 32'(bus.busy), 32'd0);
        check("async_rst core_reset", 32'(bus.core_reset), 32'd1);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        set_stream('{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44});
        run_and_check("reload");

        for (int it = 0; it < 4; it++) begin
            do_reset();
            tx_b.delete();
            tx_ok.delete();
            n = $urandom_range(1, 5);
            tx_b.push_back(8'(n));
            tx_b.push_back(8'h00);
            for (int j = 0; j < 4 * n; j++) tx_b.push_back(8'($urandom));
            foreach (tx_b[j]) tx_ok.push_back(1'b1);
            if (it == 2) tx_ok[$urandom_range(0, tx_b.size() - 1)] = 1'b0;
            if (it == 3) tx_b.delete(tx_b.size() - 1);
            if (it == 3) tx_ok.delete(tx_ok.size() - 1);
            run_and_check($sformatf("rand%0d", it));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
